// File: rtl/riscv_defines.sv
// Shared definitions for the core's memory-side blocks:
// address width plus the memory arbiter's state and owner encodings.
package riscv_defines;

  localparam int RISCV_ADDR_WIDTH = 32;

  typedef enum logic {
    IDLE,
    WAIT_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (if_*) and LSU (lsu_*) onto one memory port (mem_*),
// one outstanding transaction, LSU priority bounded by MAX_LSU_STREAK.
module mem_arbiter
  import riscv_defines::*;
#(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        if_req_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] if_addr_i,
  output logic                        if_gnt_o,
  output logic                        if_rvalid_o,
  output logic [31:0]                 if_rdata_o,
  input  logic                        lsu_req_i,
  input  logic                        lsu_we_i,
  input  logic [3:0]                  lsu_be_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]                 lsu_wdata_i,
  output logic                        lsu_gnt_o,
  output logic                        lsu_rvalid_o,
  output logic [31:0]                 lsu_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [31:0]                 mem_rdata_i
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_LSU_STREAK);

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e sticky_own;
  logic       sticky_vld;
  logic [SW-1:0] streak;

  arb_owner_e sel;
  logic       sel_req;
  logic       lsu_win;
  logic       gnt_ok;
  logic       rv;

  // LSU wins unless fetch has waited out a full streak.
  assign lsu_win = lsu_req_i && !(if_req_i && (streak == SMAX));

  always_comb begin
    sel     = OWN_IF;
    sel_req = 1'b0;
    unique case (1'b1)
      sticky_vld: begin
        // A held selection follows its own req; dropping it ends the hold.
        sel     = sticky_own;
        sel_req = (sticky_own == OWN_LSU) ? lsu_req_i : if_req_i;
      end
      (!sticky_vld && lsu_win): begin
        sel     = OWN_LSU;
        sel_req = 1'b1;
      end
      (!sticky_vld && !lsu_win && if_req_i): begin
        sel     = OWN_IF;
        sel_req = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req_o   = rst_n && (state == IDLE) && sel_req;
  assign mem_addr_o  = (sel == OWN_LSU) ? lsu_addr_i : if_addr_i;
  assign mem_we_o    = (sel == OWN_LSU) ? lsu_we_i : 1'b0;
  assign mem_be_o    = (sel == OWN_LSU) ? lsu_be_i : 4'hF;
  assign mem_wdata_o = (sel == OWN_LSU) ? lsu_wdata_i : 32'h0;

  assign gnt_ok    = mem_req_o && mem_gnt_i;
  assign if_gnt_o  = gnt_ok && (sel == OWN_IF);
  assign lsu_gnt_o = gnt_ok && (sel == OWN_LSU);

  // Responses only count while a transaction is outstanding.
  assign rv           = rst_n && (state == WAIT_RESP) && mem_rvalid_i;
  assign if_rvalid_o  = rv && (owner == OWN_IF);
  assign lsu_rvalid_o = rv && (owner == OWN_LSU);
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      sticky_own <= OWN_IF;
      sticky_vld <= 1'b0;
      streak     <= '0;
    end else begin
      if (state == IDLE) begin
        if (mem_req_o) begin
          if (mem_gnt_i) begin
            owner      <= sel;
            sticky_vld <= 1'b0;
            state      <= WAIT_RESP;
          end else begin
            sticky_vld <= 1'b1;
            sticky_own <= sel;
          end
        end else begin
          sticky_vld <= 1'b0;
        end
      end else if (mem_rvalid_i) begin
        state <= IDLE;
      end

      if (!if_req_i || if_gnt_o) begin
        streak <= '0;
      end else if (lsu_gnt_o && (streak != SMAX)) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule
